// File: rtl/rvv_backend_uop_queue_pkg.sv
// Shared types and sizing for the RVV backend uop queue between decode and dispatch.
package rvv_backend_uop_queue_pkg;

  localparam int unsigned NUM_DE_UOP   = 4;
  localparam int unsigned UQ_DEPTH     = 16;
  localparam int unsigned UQ_PTR_WIDTH = $clog2(UQ_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  vd;
    logic [2:0]  uop_index;
    logic        last_uop;
  } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_backend_uop_queue.sv
// Multi-port uop FIFO: up to 4 pushes per cycle from decode, 2 show-ahead pops to dispatch.
module rvv_backend_uop_queue
  import rvv_backend_uop_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = UQ_DEPTH,
  parameter int unsigned PUSH_N = NUM_DE_UOP,
  parameter int unsigned POP_N  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push0,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  input  UOP_QUEUE_t data0,
  input  UOP_QUEUE_t data1,
  input  UOP_QUEUE_t data2,
  input  UOP_QUEUE_t data3,
  output logic       fifo_full,
  output logic       fifo_1left_to_full,
  output logic       fifo_2left_to_full,
  output logic       fifo_3left_to_full,
  input  logic       pop0,
  input  logic       pop1,
  output UOP_QUEUE_t uop0_uq2dp,
  output UOP_QUEUE_t uop1_uq2dp,
  output logic       fifo_empty,
  output logic       fifo_1left_to_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = $clog2(PUSH_N + 1);

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [NW-1:0] off);
    return ptr + PW'(off);
  endfunction

  UOP_QUEUE_t        mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d, free;
  logic [PUSH_N-1:0] push;
  logic [POP_N-1:0]  pop;
  UOP_QUEUE_t        data [PUSH_N];
  logic [NW-1:0]     n_req, n_push;
  logic [1:0]        n_pop_req, n_pop;
  logic              gap, push_hole;

  assign push    = {push3, push2, push1, push0};
  assign pop     = {pop1, pop0};
  assign data[0] = data0;
  assign data[1] = data1;
  assign data[2] = data2;
  assign data[3] = data3;
  assign free    = CW'(DEPTH) - count_q;

  // Only the leading run of strobes counts; anything after a hole is ignored.
  always_comb begin
    n_req     = '0;
    gap       = 1'b0;
    push_hole = 1'b0;
    for (int k = 0; k < PUSH_N; k++) begin
      if (!push[k])  gap = 1'b1;
      else if (gap)  push_hole = 1'b1;
      else           n_req = n_req + 1'b1;
    end
    // Space is judged on start-of-cycle count; same-cycle pops do not free slots.
    n_push    = (CW'(n_req) > free) ? free[NW-1:0] : n_req;
    n_pop_req = pop[0] ? (pop[1] ? 2'd2 : 2'd1) : 2'd0;
    n_pop     = (CW'(n_pop_req) > count_q) ? count_q[1:0] : n_pop_req;
    wptr_d    = ptr_add(wptr_q, n_push);
    rptr_d    = rptr_q + PW'(n_pop);
    count_d   = count_q + CW'(n_push) - CW'(n_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_N; k++) begin
      if (NW'(k) < n_push) mem_q[ptr_add(wptr_q, NW'(k))] <= data[k];
    end
  end

  always_comb begin
    uop0_uq2dp = '0;
    uop1_uq2dp = '0;
    if (count_q >= CW'(1)) uop0_uq2dp = mem_q[rptr_q];
    if (count_q >= CW'(2)) uop1_uq2dp = mem_q[rptr_q + PW'(1)];
  end

  assign fifo_full           = (count_q == CW'(DEPTH));
  assign fifo_1left_to_full  = (count_q == CW'(DEPTH - 1));
  assign fifo_2left_to_full  = (count_q == CW'(DEPTH - 2));
  assign fifo_3left_to_full  = (count_q == CW'(DEPTH - 3));
  assign fifo_empty          = (count_q == '0);
  assign fifo_1left_to_empty = (count_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (CW'(n_req) <= free) else $warning("uq: push overflow, strobes dropped");
      assert (CW'(n_pop_req) <= count_q) else $warning("uq: pop underflow, pop clipped");
      assert (!push_hole) else $warning("uq: non-contiguous push strobes");
      assert (!(pop1 && !pop0)) else $warning("uq: pop1 without pop0");
    end
  end

endmodule

// File: doc/rvv_backend_uop_queue.md
# rvv_backend_uop_queue

Multi-port uop FIFO between the RVV decode stage and dispatch. Accepts up to 4 uops per cycle from decode through push0..3/data0..3 and presents the two oldest uops to dispatch with show-ahead reads. Drains up to 2 per cycle. Occupancy flags are exact-count indications; decode uses them to decide how many uops it may push in the current cycle.

## Interface
Parameters:
- DEPTH, 16: entry count; power of two, at least 4.
- PUSH_N, 4: write ports; fixed, equal to `NUM_DE_UOP.
- POP_N, 2: read ports; fixed.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- push0..push3  in  1 each  write strobes; must be contiguous (push1 implies push0, and so on).
- data0..data3  in  UOP_QUEUE_t each  write data; data0 is the oldest.
- fifo_full  out  1  count == DEPTH.
- fifo_1left_to_full  out  1  count == DEPTH-1.
- fifo_2left_to_full  out  1  count == DEPTH-2.
- fifo_3left_to_full  out  1  count == DEPTH-3.
- pop0, pop1  in  1 each  read strobes; pop1 implies pop0.
- uop0_uq2dp, uop1_uq2dp  out  UOP_QUEUE_t  oldest and second-oldest entries; zero when not present.
- fifo_empty  out  1  count == 0.
- fifo_1left_to_empty  out  1  count == 1.

## Operation
- State:
  - mem[DEPTH] of UOP_QUEUE_t, not reset.
  - wptr, rptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count: $clog2(DEPTH)+1 bits.
- Writes:
  - n_push = number of leading asserted push strobes.
  - Entry data_k is written to mem[wptr+k], for k < n_push.
  - wptr advances by n_push.
- Write overflow protection:
  - Strobe k is accepted only if k < DEPTH - count, using count at the start of the cycle.
  - Excess strobes are dropped.
  - An assertion fires on any drop.
- Non-contiguous push pattern (e.g. push0=0, push1=1):
  - Only the contiguous prefix is written.
  - An assertion fires.
- Reads:
  - uop0 = mem[rptr] when count ≥ 1, else zero.
  - uop1 = mem[rptr+1] when count ≥ 2, else zero.
  - n_pop = pop0 + (pop0 & pop1), clipped to count.
  - rptr advances by n_pop.
  - Popping beyond count, or pop1 without pop0: the pop is ignored and an assertion fires.
- Count update: count_next = count + n_push - n_pop.
  - Push and pop in the same cycle are always legal.
  - Free-space checks use count from the start of the cycle; slots freed by a same-cycle pop are not reusable until the next cycle.
- Flags are combinational decodes of registered count, so they are glitch-free with respect to inputs.
  - With DEPTH ≥ 4, at most one of the full/Nleft flags is high.
  - Decode must push at most: 0 when full, 1 at 1left, 2 at 2left, 3 at 3left, 4 otherwise.
- Pointer wrap: index arithmetic is modulo DEPTH. A 4-wide write starting at DEPTH-2 lands in entries DEPTH-2, DEPTH-1, 0, 1.
- Reset (rst high at a clk edge):
  - wptr, rptr, count = 0.
  - Memory contents are don't-care.
  - Reset overrides any same-cycle push or pop. Pushes in that cycle are lost.

## Timing
- Reset values: fifo_empty=1; fifo_1left_to_empty=0; all fifo_*full flags=0; uop0_uq2dp=0; uop1_uq2dp=0.
- Write-to-read latency is 1 cycle. A uop pushed at edge N is visible on uop0/uop1 after edge N, with no same-cycle bypass.
  - Push into an empty queue while pop0=1 in the same cycle: the pop is ignored.
- Pop effect is 1 cycle. After the edge that consumes a pop, the outputs show the next entries.
- All outputs come from registers through a mux and count compare only; no input-to-output combinational path.

## Structure
- Add to rvv_backend.svh:
  - `UQ_DEPTH (16)
  - `UQ_PTR_WIDTH
  - reuse of UOP_QUEUE_t and `NUM_DE_UOP
- Single module, no sub-module. Pointer-plus-offset adds are local functions.
- Assertions go in rvv_backend_sva.svh macros: overflow, underflow, non-contiguous push, non-contiguous pop.

## Test plan
- Reset, then idle. Required: fifo_empty=1, all full flags 0, uop0=uop1=0, held across 5 cycles.
- Push 4 uops tagged A–D in cycle 0, then pop0+pop1 in cycles 1 and 2. Required:
  - cycle 1: uop0=A, uop1=B
  - cycle 2: uop0=C, uop1=D
  - cycle 3: fifo_empty=1
- Fill DEPTH=16 with pushes of 4, 4, 4, 3. Required: fifo_1left_to_full=1, then after one more single push fifo_full=1. A 2-push while full writes nothing, fires the assertion, and count stays 16.
- Wrap: advance pointers to 14, push 4 uops E–H, pop 2 per cycle. Required: order E, F, G, H preserved across the wrap.
- Simultaneous 3-push and 2-pop at count=5. Required: count=6 next cycle, and uop0 is the 3rd-oldest prior entry.
- Assert rst mid-stream at count=9 with push0..3 high. Required: next cycle count=0, fifo_empty=1, uop0=0.
